// File: rtl/pixel_region_logic_param.sv
// pixel_region_logic_param
// A region of NPIX pixels that share a MEM_DEPTH-slot latency buffer. The
// region captures Time-over-Threshold per pixel, waits out the trigger latency,
// tags triggered hits and reads them out through a token chain.
// Optional build macro PRL_OVF_CNT_EN: when defined, OvfCnt is a saturating
// count of dropped leading edges; otherwise OvfCnt is tied to zero.

module pixel_region_logic_param #(
    parameter int NPIX      = 4,
    parameter int TOT_W     = 4,
    parameter int MEM_DEPTH = 8,
    parameter int LAT_W     = 9,
    parameter int TRIG_W    = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NPIX-1:0]       Hit,
    input  logic [NPIX-1:0]       PwrDwn,
    input  logic [LAT_W-1:0]      LatCnt,
    input  logic [LAT_W-1:0]      LatCntReq,
    input  logic                  L1Trig,
    input  logic [TRIG_W-1:0]     TrigId,
    input  logic [TRIG_W-1:0]     TrigIdReq,
    input  logic                  Read,
    input  logic                  TokIn,
    output logic                  TokOut,
    output logic [NPIX*TOT_W-1:0] DataToCore,
    output logic                  Overflow,
    output logic [7:0]            OvfCnt
);

    localparam int SW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int DW = NPIX * TOT_W;
    localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};
    localparam logic [TOT_W-1:0] TOT_ONE = TOT_W'(1);

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_WAIT = 2'd1,
        SLOT_TRIG = 2'd2
    } slot_state_t;

    // Per-slot storage
    slot_state_t         state_r [MEM_DEPTH];
    slot_state_t         state_s [MEM_DEPTH];
    logic [LAT_W-1:0]    ts_r    [MEM_DEPTH];
    logic [TRIG_W-1:0]   tag_r   [MEM_DEPTH];
    logic [DW-1:0]       tot_r   [MEM_DEPTH];
    // trk_r[s][p]: pixel p is still integrating its ToT into slot s
    logic [NPIX-1:0]     trk_r   [MEM_DEPTH];

    logic [NPIX-1:0]      hit_prev_r;
    logic                 region_on_s;
    logic [NPIX-1:0]      hit_act_s;
    logic [NPIX-1:0]      le_s;
    logic [MEM_DEPTH-1:0] free_vec_s;
    logic [MEM_DEPTH-1:0] expire_vec_s;
    logic [MEM_DEPTH-1:0] match_vec_s;
    logic                 any_free_s;
    logic                 any_match_s;
    logic                 alloc_s;
    logic                 ovf_s;
    logic                 read_fire_s;
    logic [SW-1:0]        alloc_idx_s;
    logic [SW-1:0]        rd_idx_s;
    logic [DW-1:0]        data_s;

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [SW-1:0] lowest_idx(input logic [MEM_DEPTH-1:0] vec);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = MEM_DEPTH - 1; i >= 0; i--) begin
            idx = vec[i] ? SW'(i) : idx;
        end
        return idx;
    endfunction

    // Pixel qualification, leading-edge detection, slot scan and readout selection.
    always_comb begin
        region_on_s  = ~(&PwrDwn);
        hit_act_s    = Hit & ~PwrDwn;
        le_s         = Hit & ~hit_prev_r & ~PwrDwn;
        free_vec_s   = '0;
        expire_vec_s = '0;
        match_vec_s  = '0;
        for (int s = 0; s < MEM_DEPTH; s++) begin
            free_vec_s[s]   = (state_r[s] == SLOT_FREE);
            // Equality on LAT_W bits is naturally modulo 2^LAT_W, so BX wrap is handled.
            expire_vec_s[s] = region_on_s && (state_r[s] == SLOT_WAIT) && (LatCntReq == ts_r[s]);
            match_vec_s[s]  = region_on_s && (state_r[s] == SLOT_TRIG) && (tag_r[s] == TrigIdReq);
        end
        any_free_s  = |free_vec_s;
        any_match_s = |match_vec_s;
        alloc_idx_s = lowest_idx(free_vec_s);
        rd_idx_s    = lowest_idx(match_vec_s);
        alloc_s     = region_on_s && (|le_s) && any_free_s;
        ovf_s       = (|le_s) && !any_free_s;
        read_fire_s = TokIn && any_match_s && Read;
    end

    // Slot next-state: FREE -> WAIT -> (TRIG | FREE), TRIG -> FREE on readout.
    always_comb begin
        for (int s = 0; s < MEM_DEPTH; s++) begin
            state_s[s] = state_r[s];
            case (state_r[s])
                SLOT_FREE: begin
                    state_s[s] = (alloc_s && (alloc_idx_s == SW'(s))) ? SLOT_WAIT : SLOT_FREE;
                end
                SLOT_WAIT: begin
                    if (expire_vec_s[s]) begin
                        state_s[s] = L1Trig ? SLOT_TRIG : SLOT_FREE;
                    end else begin
                        state_s[s] = SLOT_WAIT;
                    end
                end
                SLOT_TRIG: begin
                    state_s[s] = (read_fire_s && (rd_idx_s == SW'(s))) ? SLOT_FREE : SLOT_TRIG;
                end
                default: begin
                    state_s[s] = SLOT_FREE;
                end
            endcase
        end
    end

    // Slot state register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int s = 0; s < MEM_DEPTH; s++) begin
                state_r[s] <= SLOT_FREE;
            end
        end else begin
            for (int s = 0; s < MEM_DEPTH; s++) begin
                state_r[s] <= state_s[s];
            end
        end
    end

    // Slot payload: timestamp, trigger tag, per-pixel ToT and tracking bits.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int s = 0; s < MEM_DEPTH; s++) begin
                ts_r[s]  <= '0;
                tag_r[s] <= '0;
                tot_r[s] <= '0;
                trk_r[s] <= '0;
            end
        end else begin
            for (int s = 0; s < MEM_DEPTH; s++) begin
                if (alloc_s && (alloc_idx_s == SW'(s))) begin
                    ts_r[s]  <= LatCnt;
                    tag_r[s] <= '0;
                    trk_r[s] <= le_s;
                    for (int p = 0; p < NPIX; p++) begin
                        tot_r[s][p*TOT_W +: TOT_W] <= le_s[p] ? TOT_ONE : '0;
                    end
                end else begin
                    // A trailing edge (or power-down) ends integration for that pixel.
                    trk_r[s] <= trk_r[s] & hit_act_s;
                    if (expire_vec_s[s] && L1Trig) begin
                        tag_r[s] <= TrigId;
                    end
                    // Counting stops on the expiry cycle, freezing the ToT seen then.
                    for (int p = 0; p < NPIX; p++) begin
                        if (trk_r[s][p] && hit_act_s[p] && (state_r[s] == SLOT_WAIT) &&
                            !expire_vec_s[s] && (tot_r[s][p*TOT_W +: TOT_W] != TOT_MAX)) begin
                            tot_r[s][p*TOT_W +: TOT_W] <= tot_r[s][p*TOT_W +: TOT_W] + TOT_ONE;
                        end
                    end
                end
            end
        end
    end

    // Previous-cycle discriminator levels for leading-edge detection.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hit_prev_r <= '0;
        end else begin
            hit_prev_r <= Hit;
        end
    end

    // Readout bus carries the lowest matching slot only while this region holds the token.
    always_comb begin
        data_s = read_fire_s ? tot_r[rd_idx_s] : '0;
    end

    assign DataToCore = data_s;
    assign TokOut     = TokIn & ~any_match_s;
    assign Overflow   = ovf_s;

`ifdef PRL_OVF_CNT_EN
    logic [7:0] ovf_cnt_r;

    // Saturating count of dropped leading edges, cleared only by reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ovf_cnt_r <= 8'd0;
        end else if (ovf_s && (ovf_cnt_r != 8'hFF)) begin
            ovf_cnt_r <= ovf_cnt_r + 8'd1;
        end
    end

    assign OvfCnt = ovf_cnt_r;
`else
    assign OvfCnt = 8'd0;
`endif

endmodule

// File: tb/tb_pixel_region_logic_param.sv
// Testbench for pixel_region_logic_param: directed scenarios followed by a
// randomized phase, all compared against a slot-level reference model.

module tb_pixel_region_logic_param;

    localparam int NPIX      = 4;
    localparam int TOT_W     = 4;
    localparam int MEM_DEPTH = 8;
    localparam int LAT_W     = 9;
    localparam int TRIG_W    = 5;
    localparam int TOT_MAX   = 15;
`ifdef PRL_OVF_CNT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic [3:0]  Hit;
    logic [3:0]  PwrDwn;
    logic [8:0]  LatCnt;
    logic [8:0]  LatCntReq;
    logic        L1Trig;
    logic [4:0]  TrigId;
    logic [4:0]  TrigIdReq;
    logic        Read;
    logic        TokIn;
    logic        TokOut;
    logic [15:0] DataToCore;
    logic        Overflow;
    logic [7:0]  OvfCnt;

    int errors = 0;
    int checks = 0;
    int lat_cfg;
    bit rand_mode;
    bit         trig_map    [512];
    logic [4:0] trig_id_map [512];
    logic [8:0] bx;

    // Reference model: slot status 0=free 1=waiting 2=triggered
    int m_state [MEM_DEPTH];
    int m_ts    [MEM_DEPTH];
    int m_tag   [MEM_DEPTH];
    int m_tot   [MEM_DEPTH][NPIX];
    bit m_trk   [MEM_DEPTH][NPIX];
    bit m_hprev [NPIX];
    int m_ovf;

    bit          e_tok;
    bit          e_ovf;
    bit          e_fire;
    logic [15:0] e_data;
    int          e_rd;
    int          e_alloc;
    bit   [3:0]  e_le;

    pixel_region_logic_param #(
        .NPIX(NPIX), .TOT_W(TOT_W), .MEM_DEPTH(MEM_DEPTH), .LAT_W(LAT_W), .TRIG_W(TRIG_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Hit(Hit), .PwrDwn(PwrDwn), .LatCnt(LatCnt),
        .LatCntReq(LatCntReq), .L1Trig(L1Trig), .TrigId(TrigId), .TrigIdReq(TrigIdReq),
        .Read(Read), .TokIn(TokIn), .TokOut(TokOut), .DataToCore(DataToCore),
        .Overflow(Overflow), .OvfCnt(OvfCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < MEM_DEPTH; s++) begin
            m_state[s] = 0;
            m_ts[s]    = 0;
            m_tag[s]   = 0;
            for (int p = 0; p < NPIX; p++) begin
                m_tot[s][p] = 0;
                m_trk[s][p] = 1'b0;
            end
        end
        for (int p = 0; p < NPIX; p++) m_hprev[p] = 1'b0;
        m_ovf = 0;
    endtask

    // Expected combinational outputs for the current inputs and model state.
    task automatic model_comb();
        bit on;
        on      = (PwrDwn != 4'hF);
        e_le    = 4'h0;
        e_alloc = -1;
        e_rd    = -1;
        for (int p = 0; p < NPIX; p++) e_le[p] = Hit[p] && !m_hprev[p] && !PwrDwn[p];
        for (int s = MEM_DEPTH - 1; s >= 0; s--) begin
            if (m_state[s] == 0) e_alloc = s;
            if (on && m_state[s] == 2 && m_tag[s] == int'(TrigIdReq)) e_rd = s;
        end
        e_ovf  = (e_le != 4'h0) && (e_alloc < 0);
        e_tok  = TokIn && (e_rd < 0);
        e_fire = TokIn && Read && (e_rd >= 0);
        e_data = 16'h0000;
        if (e_fire) begin
            for (int p = 0; p < NPIX; p++) e_data[p*4 +: 4] = 4'(m_tot[e_rd][p]);
        end
    endtask

    // Advance the model by one clock edge using the inputs of the cycle just ended.
    task automatic model_clock();
        bit on;
        bit fresh;
        on = (PwrDwn != 4'hF);
        for (int s = 0; s < MEM_DEPTH; s++) begin
            fresh = 1'b0;
            if (on && m_state[s] == 1) begin
                if (LatCntReq == 9'(m_ts[s])) begin
                    m_state[s] = L1Trig ? 2 : 0;
                    if (L1Trig) m_tag[s] = int'(TrigId);
                end else begin
                    for (int p = 0; p < NPIX; p++)
                        if (m_trk[s][p] && Hit[p] && !PwrDwn[p] && m_tot[s][p] < TOT_MAX)
                            m_tot[s][p]++;
                end
            end else if (on && m_state[s] == 2 && e_fire && e_rd == s) begin
                m_state[s] = 0;
            end else if (on && m_state[s] == 0 && e_alloc == s && e_le != 4'h0) begin
                m_state[s] = 1;
                m_ts[s]    = int'(LatCnt);
                m_tag[s]   = 0;
                fresh      = 1'b1;
                for (int p = 0; p < NPIX; p++) begin
                    m_tot[s][p] = e_le[p] ? 1 : 0;
                    m_trk[s][p] = e_le[p];
                end
            end
            if (!fresh) begin
                for (int p = 0; p < NPIX; p++) m_trk[s][p] = m_trk[s][p] && Hit[p] && !PwrDwn[p];
            end
        end
        for (int p = 0; p < NPIX; p++) m_hprev[p] = Hit[p];
        if (e_ovf && m_ovf < 255) m_ovf++;
    endtask

    task automatic settle();
        LatCntReq = LatCnt - 9'(lat_cfg);
        if (!rand_mode) begin
            L1Trig = trig_map[LatCntReq];
            TrigId = trig_id_map[LatCntReq];
        end
        #1;
    endtask

    // One clock cycle: check outputs mid-cycle, then step the model at the edge.
    task automatic step();
        settle();
        @(negedge Clk);
        model_comb();
        chk("tokout", {31'd0, TokOut}, {31'd0, e_tok});
        chk("data", {16'd0, DataToCore}, {16'd0, e_data});
        chk("overflow", {31'd0, Overflow}, {31'd0, e_ovf});
        chk("ovfcnt", {24'd0, OvfCnt}, OVF_EN ? 32'(m_ovf) : 32'd0);
        @(posedge Clk);
        model_clock();
        if (!rand_mode && L1Trig) trig_map[LatCntReq] = 1'b0;
        #1;
        LatCnt = LatCnt + 9'd1;
    endtask

    initial begin
        Reset = 1'b0; Hit = 4'h0; PwrDwn = 4'h0; LatCnt = 9'd0; LatCntReq = 9'd0;
        L1Trig = 1'b0; TrigId = 5'd0; TrigIdReq = 5'd0; Read = 1'b0; TokIn = 1'b1;
        lat_cfg = 20; rand_mode = 1'b0;
        for (int i = 0; i < 512; i++) begin
            trig_map[i] = 1'b0;
            trig_id_map[i] = 5'd0;
        end
        model_reset();
        #1;
        chk("rst_tokout", {31'd0, TokOut}, 32'd1);
        chk("rst_data", {16'd0, DataToCore}, 32'd0);
        chk("rst_overflow", {31'd0, Overflow}, 32'd0);
        chk("rst_ovfcnt", {24'd0, OvfCnt}, 32'd0);
        TokIn = 1'b0;
        #1;
        chk("rst_tok_follow", {31'd0, TokOut}, 32'd0);
        TokIn = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        // 1: single pixel, ToT 5, triggered with tag 3
        while (LatCnt != 9'd10) step();
        trig_map[10] = 1'b1; trig_id_map[10] = 5'd3; TrigIdReq = 5'd3;
        Hit = 4'b0100;
        repeat (5) step();
        Hit = 4'b0000;
        while (LatCnt != 9'd31) step();
        settle();
        chk("t1_tok_held", {31'd0, TokOut}, 32'd0);
        Read = 1'b1;
        settle();
        chk("t1_data", {16'd0, DataToCore}, 32'h0500);
        step();
        Read = 1'b0;
        settle();
        chk("t1_tok_free", {31'd0, TokOut}, 32'd1);

        // 2: two pixels share one slot, ToT 2 and 7
        trig_map[40] = 1'b1; trig_id_map[40] = 5'd5; TrigIdReq = 5'd5;
        while (LatCnt != 9'd40) step();
        Hit = 4'b1001;
        repeat (2) step();
        Hit = 4'b1000;
        repeat (5) step();
        Hit = 4'b0000;
        while (LatCnt != 9'd61) step();
        Read = 1'b1;
        settle();
        chk("t2_data", {16'd0, DataToCore}, 32'h7002);
        step();
        settle();
        chk("t2_single_slot", {31'd0, TokOut}, 32'd1);
        Read = 1'b0;

        // 3: nine leading edges, no trigger -> ninth overflows
        for (int k = 0; k < 9; k++) begin
            Hit = 4'b0010;
            if (k == 8) begin
                settle();
                chk("t3_overflow", {31'd0, Overflow}, 32'd1);
            end
            step();
            Hit = 4'b0000;
            step();
        end
        chk("t3_ovfcnt", {24'd0, OvfCnt}, OVF_EN ? 32'd1 : 32'd0);
        repeat (20) step();

        // 4a: long hit saturates ToT
        lat_cfg = 30;
        bx = LatCnt;
        trig_map[bx] = 1'b1; trig_id_map[bx] = 5'd9; TrigIdReq = 5'd9;
        Hit = 4'b0010;
        repeat (20) step();
        Hit = 4'b0000;
        while (LatCnt != bx + 9'd31) step();
        Read = 1'b1;
        settle();
        chk("t4_saturate", {16'd0, DataToCore}, 32'h00F0);
        step();
        Read = 1'b0;

        // 4b: expiry while hit is still high freezes ToT
        lat_cfg = 6;
        bx = LatCnt;
        trig_map[bx] = 1'b1; trig_id_map[bx] = 5'd10; TrigIdReq = 5'd10;
        Hit = 4'b0100;
        repeat (10) step();
        Hit = 4'b0000;
        step();
        Read = 1'b1;
        settle();
        chk("t4_frozen", {16'd0, DataToCore}, 32'h0600);
        step();
        Read = 1'b0;

        // 5: timestamp 510 across counter wrap, with and without trigger
        lat_cfg = 5;
        LatCnt = 9'd508;
        step(); step();
        trig_map[510] = 1'b1; trig_id_map[510] = 5'd7; TrigIdReq = 5'd7;
        Hit = 4'b0001;
        step();
        Hit = 4'b0000;
        while (LatCnt != 9'd4) step();
        Read = 1'b1;
        settle();
        chk("t5_wrap_data", {16'd0, DataToCore}, 32'h0001);
        step();
        Read = 1'b0;
        LatCnt = 9'd510;
        Hit = 4'b0001;
        step();
        Hit = 4'b0000;
        while (LatCnt != 9'd4) step();
        settle();
        chk("t5_tok_pass", {31'd0, TokOut}, 32'd1);
        TokIn = 1'b0;
        settle();
        chk("t5_tok_pass0", {31'd0, TokOut}, 32'd0);
        TokIn = 1'b1;

        // 6a: whole region powered down
        bx = LatCnt;
        trig_map[bx] = 1'b1; trig_id_map[bx] = 5'd12; TrigIdReq = 5'd12;
        PwrDwn = 4'hF;
        Hit = 4'b1111;
        settle();
        chk("t6_off_ovf", {31'd0, Overflow}, 32'd0);
        repeat (2) step();
        Hit = 4'b0000;
        step();
        PwrDwn = 4'h0;
        while (LatCnt != bx + 9'd7) step();
        settle();
        chk("t6_no_alloc", {31'd0, TokOut}, 32'd1);

        // 6b: reset while two slots are triggered
        bx = LatCnt;
        trig_map[bx] = 1'b1; trig_id_map[bx] = 5'd2;
        trig_map[bx + 9'd2] = 1'b1; trig_id_map[bx + 9'd2] = 5'd2;
        TrigIdReq = 5'd2;
        Hit = 4'b0001; step();
        Hit = 4'b0000; step();
        Hit = 4'b0010; step();
        Hit = 4'b0000;
        while (LatCnt != bx + 9'd8) step();
        settle();
        chk("t6_tok_two", {31'd0, TokOut}, 32'd0);
        Read = 1'b1;
        settle();
        chk("t6_data_pre", {16'd0, DataToCore}, 32'h0001);
        Reset = 1'b0;
        #1;
        chk("t6_rst_data", {16'd0, DataToCore}, 32'd0);
        chk("t6_rst_tok", {31'd0, TokOut}, 32'd1);
        chk("t6_rst_ovfcnt", {24'd0, OvfCnt}, 32'd0);
        model_reset();
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        Read = 1'b0;
        @(posedge Clk);
        #1;
        repeat (3) step();

        // Randomized phase
        rand_mode = 1'b1;
        lat_cfg = 8;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) Hit = Hit ^ 4'($urandom);
            PwrDwn    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            L1Trig    = ($urandom_range(0, 2) == 0);
            TrigId    = 5'($urandom_range(0, 3));
            TrigIdReq = 5'($urandom_range(0, 3));
            TokIn     = ($urandom_range(0, 3) != 0);
            Read      = ($urandom_range(0, 1) == 1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_region_logic_param.md
Name: pixel_region_logic_param

Overview:
Parametrised next-generation pixel region: NPIX pixels share a MEM_DEPTH-slot latency buffer.
- Per-pixel Time-over-Threshold (ToT) capture.
- Latency expiry with L1 trigger tagging.
- Token-chained readout onto a core data bus.
- Per-pixel power-down, buffer-overflow detection and an optional overflow counter.
Sits between the analog-front-end discriminator outputs and the core-column readout chain.

Parameters:
NPIX, 4, pixels per region
TOT_W, 4, ToT bits per pixel
MEM_DEPTH, 8, latency buffer slots
LAT_W, 9, latency/BX counter width
TRIG_W, 5, trigger ID width

Ports:
Clk  in  1  40 MHz BX clock
Reset  in  1  asynchronous, active-low reset
Hit  in  NPIX  discriminator outputs; already synchronous to Clk
PwrDwn  in  NPIX  per-pixel disable
LatCnt  in  LAT_W  free-running BX counter
LatCntReq  in  LAT_W  LatCnt minus configured latency; supplied by core
L1Trig  in  1  L1 trigger for the BX at LatCntReq
TrigId  in  TRIG_W  tag assigned to the current L1Trig
TrigIdReq  in  TRIG_W  tag currently being read out
Read  in  1  readout strobe
TokIn  in  1  token from previous region
TokOut  out  1  token to next region
DataToCore  out  NPIX*TOT_W  ToT bus; pixel p at [p*TOT_W +: TOT_W]; 0 when not driving
Overflow  out  1  one-cycle pulse: leading edge lost, buffer full
OvfCnt  out  8  overflow count (see Optional Feature)

Behaviour:
- Reset (Reset=0, async) values:
  - All slots FREE; all ToT counters 0.
  - TokOut = TokIn (combinational; no stored triggered data).
  - DataToCore = 0; Overflow = 0; OvfCnt = 0.
- Pixel enable: pixel p is active iff PwrDwn[p]=0. If all pixels are disabled, the region is off:
  - No allocation.
  - TokOut = TokIn; DataToCore = 0.
  - Slot state is held frozen.
- Leading edge (LE): Hit[p]=1 with Hit[p]=0 on the previous cycle, pixel active.
  - All pixels with an LE in the same cycle share one slot: the lowest-index FREE slot.
  - The slot stores ts=LatCnt and goes FREE->WAIT.
  - Each contributing pixel's ToT starts at 1 in that cycle.
- ToT accumulation:
  - +1 per cycle while Hit[p]=1, saturating at 2^TOT_W-1.
  - Pixels not in the slot keep ToT=0.
  - Trailing edge stops the count.
  - A new LE on the same pixel allocates a new slot.
- Slot FSM: FREE -> WAIT -> (TRIG | FREE) -> FREE.
  - WAIT, on the cycle LatCntReq==ts (compare modulo 2^LAT_W, wrap-around correct):
    - L1Trig=1: go to TRIG and store tag=TrigId. ToT is frozen at its current value even if Hit is still high.
    - L1Trig=0: go to FREE in the next cycle.
  - TRIG: waits for readout.
- Readout:
  - match = any TRIG slot with tag==TrigIdReq.
  - TokOut = TokIn & ~match.
  - When TokIn & match & Read, DataToCore combinationally carries the lowest-index matching slot. That slot goes FREE at the next Clk edge.
  - Multiple matching slots hold the token across successive Read cycles, one slot per cycle.
- Full buffer:
  - An LE with no FREE slot is dropped: no ToT capture, Overflow=1 for that cycle.
  - A slot freed in the same cycle is not available until the next cycle.
- Simultaneous events:
  - A slot may expire and another may be allocated in the same cycle.
  - Read-free and allocation in the same cycle: allocation does not use the slot being freed.
- Reset mid-operation discards all slots immediately; the token passes through from the next evaluation.

Optional Feature:
PRL_OVF_CNT_EN:
- Defined: OvfCnt increments on each Overflow pulse, saturating at 255. Cleared only by Reset.
- Undefined: OvfCnt tied to 0 and no counter logic is synthesised.

Test Plan:
1. Defaults; Hit[2]=1 for 5 cycles at LatCnt=10; L1Trig at LatCntReq=10, TrigId=3; TrigIdReq=3, TokIn=1, Read -> TokOut=0, DataToCore=0x0500, then slot FREE and TokOut=1.
2. Hit[0] and Hit[3] rise in the same cycle, ToT 2 and 7 -> one slot used; readout gives 0x7002.
3. 9 distinct LEs with no trigger before the first expiry -> 9th LE gives an Overflow pulse; OvfCnt=1 when PRL_OVF_CNT_EN is defined, 0 otherwise.
4. Hit held 20 cycles with TOT_W=4 -> ToT saturates at 15. Separately, expiry while Hit is still high -> ToT frozen at the expiry-cycle value.
5. ts=510, LatCnt wraps past 511 -> expiry occurs at LatCntReq=510; no trigger -> slot FREE, TokOut=TokIn.
6. PwrDwn=4'hF with hits -> no allocation, TokOut follows TokIn. Reset=0 while two slots are TRIG -> all FREE, DataToCore=0 immediately.
